src_control_unit: RTL and testbench

- Hardwired Moore control sequencer for the Mini SRC DataPath.
- Runs instruction fetch (T0–T2), decodes IR[31:27], then steps the execute phase (T3–T7) with the exact bus, register-enable, ALU and memory strobes the DataPath expects.
- Replaces hand-driven stimulus sequences. Sits beside DataPath and consumes IR contents, CON FF output and a memory-ready flag.

---
 rtl/src_control_unit_if.sv | 29 ++
 rtl/src_control_unit.sv | 142 ++++++++++++++
 tb/tb_src_control_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/src_control_unit_if.sv
// Signal bundle between the Mini SRC control sequencer and its DataPath.
// The sequencer is the master: it drives strobes and observes IR, CON FF and memory ready.
interface src_control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_rdy;
    logic        Gra, Grb, Grc;
    logic        Rin, Rout, BAout;
    logic        Pout, Cout, ZLOout, MDROut;
    logic        Pen, MARen, MDRen, IRen, Yen, Zen, ConIn;
    logic        IncPC;
    logic        Read, Write;
    logic [4:0]  alu_control;
    logic        run;

    modport master (
        input  ir, con_ff, mem_rdy,
        output Gra, Grb, Grc, Rin, Rout, BAout, Pout, Cout, ZLOout, MDROut,
               Pen, MARen, MDRen, IRen, Yen, Zen, ConIn, IncPC, Read, Write,
               alu_control, run
    );

    modport slave (
        output ir, con_ff, mem_rdy,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Pout, Cout, ZLOout, MDROut,
               Pen, MARen, MDRen, IRen, Yen, Zen, ConIn, IncPC, Read, Write,
               alu_control, run
    );
endinterface

// File: rtl/src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC DataPath: fetch T0-T2, decode, execute T3-T7.
// All strobes decode from the state register and the opcode latched at the T2->T3 edge.
module src_control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic                clk,
    input  logic                clr,
    src_control_unit_if.master  ctl
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_T6_TK, S_T6_NT, S_HALTED
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t     r_state, w_next;
    logic [4:0] r_op;
    logic       w_is_mem, w_is_reg, w_is_imm, w_is_exec;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (clr) begin
            r_state <= S_RESET;
            r_op    <= 5'b00000;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2)
                r_op <= ctl.ir[31:27];
        end
    end

    assign w_is_mem  = (r_op == OP_LD) || (r_op == OP_LDI) || (r_op == OP_ST);
    assign w_is_reg  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_AND) || (r_op == OP_OR);
    assign w_is_imm  = (r_op == OP_ADDI) || (r_op == OP_ANDI) || (r_op == OP_ORI);
    assign w_is_exec = w_is_mem || w_is_reg || w_is_imm || (r_op == OP_BR);

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path infers a latch.
        w_next          = r_state;
        ctl.Gra         = 1'b0; ctl.Grb    = 1'b0; ctl.Grc   = 1'b0;
        ctl.Rin         = 1'b0; ctl.Rout   = 1'b0; ctl.BAout = 1'b0;
        ctl.Pout        = 1'b0; ctl.Cout   = 1'b0; ctl.ZLOout = 1'b0; ctl.MDROut = 1'b0;
        ctl.Pen         = 1'b0; ctl.MARen  = 1'b0; ctl.MDRen = 1'b0; ctl.IRen = 1'b0;
        ctl.Yen         = 1'b0; ctl.Zen    = 1'b0; ctl.ConIn = 1'b0;
        ctl.IncPC       = 1'b0; ctl.Read   = 1'b0; ctl.Write = 1'b0;
        ctl.alu_control = 5'b00000;
        ctl.run         = 1'b1;

        unique case (r_state)
            S_RESET: w_next = S_T0;
            S_T0: begin
                ctl.Pout = 1'b1; ctl.MARen = 1'b1; ctl.IncPC = 1'b1; ctl.Zen = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                ctl.ZLOout = 1'b1; ctl.Pen = 1'b1; ctl.Read = 1'b1; ctl.MDRen = 1'b1;
                w_next = ctl.mem_rdy ? S_T2 : S_T1;
            end
            S_T2: begin
                ctl.MDROut = 1'b1; ctl.IRen = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                if (w_is_mem) begin
                    ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Yen = 1'b1;
                end else if (w_is_reg || w_is_imm) begin
                    ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Yen = 1'b1;
                end else if (r_op == OP_BR) begin
                    ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.ConIn = 1'b1;
                end
                if (r_op == OP_HALT)  w_next = S_HALTED;
                else if (w_is_exec)   w_next = S_T4;
                else                  w_next = S_T0;
            end
            S_T4: begin
                if (r_op == OP_BR) begin
                    ctl.Pout = 1'b1; ctl.Yen = 1'b1;
                end else if (w_is_reg) begin
                    ctl.Grc = 1'b1; ctl.Rout = 1'b1; ctl.Zen = 1'b1;
                    ctl.alu_control = r_op;
                end else begin
                    ctl.Cout = 1'b1; ctl.Zen = 1'b1;
                    unique case (r_op)
                        OP_ANDI: ctl.alu_control = OP_AND;
                        OP_ORI:  ctl.alu_control = OP_OR;
                        default: ctl.alu_control = ADD_OP;
                    endcase
                end
                w_next = S_T5;
            end
            S_T5: begin
                if (r_op == OP_BR) begin
                    ctl.Cout = 1'b1; ctl.alu_control = ADD_OP; ctl.Zen = 1'b1;
                    w_next = ctl.con_ff ? S_T6_TK : S_T6_NT;
                end else if ((r_op == OP_LD) || (r_op == OP_ST)) begin
                    ctl.ZLOout = 1'b1; ctl.MARen = 1'b1;
                    w_next = S_T6;
                end else begin
                    ctl.ZLOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
                    w_next = S_T0;
                end
            end
            S_T6: begin
                if (r_op == OP_ST) begin
                    ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.MDRen = 1'b1;
                    w_next = S_T7;
                end else begin
                    ctl.Read = 1'b1; ctl.MDRen = 1'b1;
                    w_next = ctl.mem_rdy ? S_T7 : S_T6;
                end
            end
            S_T6_TK: begin
                ctl.ZLOout = 1'b1; ctl.Pen = 1'b1;
                w_next = S_T0;
            end
            S_T6_NT: w_next = S_T0;
            S_T7: begin
                if (r_op == OP_ST) begin
                    ctl.Write = 1'b1;
                    w_next = ctl.mem_rdy ? S_T0 : S_T7;
                end else begin
                    ctl.MDROut = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
                    w_next = S_T0;
                end
            end
            S_HALTED: ctl.run = 1'b0;
            default:  w_next = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_src_control_unit.sv
// Scoreboard bench for src_control_unit: per-cycle expected strobe vectors are queued with
// their mem_rdy/clr stimulus, then popped and compared against the DUT at each falling edge.
module tb_src_control_unit;
    logic clk = 1'b0;
    logic clr;
    src_control_unit_if ifc ();

    src_control_unit #(.ADD_OP(5'b00011)) dut (
        .clk (clk),
        .clr (clr),
        .ctl (ifc.master)
    );

    always #5 clk = ~clk;

    // Packed view: bit 0 = Gra ... bit 20 = run, [25:21] = alu_control.
    localparam logic [25:0] GRA  = 26'd1 << 0,  GRB  = 26'd1 << 1,  GRC  = 26'd1 << 2;
    localparam logic [25:0] RIN  = 26'd1 << 3,  ROUT = 26'd1 << 4,  BAO  = 26'd1 << 5;
    localparam logic [25:0] POUT = 26'd1 << 6,  COUT = 26'd1 << 7,  ZLO  = 26'd1 << 8;
    localparam logic [25:0] MDRO = 26'd1 << 9,  PEN  = 26'd1 << 10, MARE = 26'd1 << 11;
    localparam logic [25:0] MDRE = 26'd1 << 12, IREN = 26'd1 << 13, YEN  = 26'd1 << 14;
    localparam logic [25:0] ZEN  = 26'd1 << 15, CONI = 26'd1 << 16, INCP = 26'd1 << 17;
    localparam logic [25:0] RD   = 26'd1 << 18, WR   = 26'd1 << 19, RUN  = 26'd1 << 20;

    localparam logic [25:0] E_RESET = RUN;
    localparam logic [25:0] E_T0    = RUN | POUT | MARE | INCP | ZEN;
    localparam logic [25:0] E_T1    = RUN | ZLO | PEN | RD | MDRE;
    localparam logic [25:0] E_T2    = RUN | MDRO | IREN;
    localparam logic [25:0] E_MEM3  = RUN | GRB | BAO | YEN;
    localparam logic [25:0] E_REG3  = RUN | GRB | ROUT | YEN;
    localparam logic [25:0] E_WB5   = RUN | ZLO | GRA | RIN;
    localparam logic [25:0] E_MAR5  = RUN | ZLO | MARE;

    logic [25:0] q_exp[$];
    bit          q_mrdy[$];
    bit          q_clr[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [25:0] obs, exp_v;

    function automatic logic [25:0] alu(input logic [4:0] op);
        return {op, 21'd0};
    endfunction

    function automatic logic [25:0] pack();
        return {ifc.alu_control, ifc.run, ifc.Write, ifc.Read, ifc.IncPC, ifc.ConIn,
                ifc.Zen, ifc.Yen, ifc.IRen, ifc.MDRen, ifc.MARen, ifc.Pen, ifc.MDROut,
                ifc.ZLOout, ifc.Cout, ifc.Pout, ifc.BAout, ifc.Rout, ifc.Rin, ifc.Grc,
                ifc.Grb, ifc.Gra};
    endfunction

    task automatic push(input logic [25:0] e, input bit mr = 1'b1, input bit cl = 1'b0);
        q_exp.push_back(e);
        q_mrdy.push_back(mr);
        q_clr.push_back(cl);
    endtask

    task automatic push_fetch(input int t1_stalls);
        push(E_T0);
        repeat (t1_stalls) push(E_T1, 1'b0);
        push(E_T1, 1'b1);
        push(E_T2);
    endtask

    // Apply the head stimulus for one cycle and stop at the falling edge for sampling.
    task automatic drive_to_sample();
        ifc.mem_rdy = q_mrdy.pop_front();
        clr         = q_clr.pop_front();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; ifc.mem_rdy = 1'b1; ifc.con_ff = 1'b0; ifc.ir = 32'h0;
        advance();
        push(E_RESET, 1'b1, 1'b1);
        push(E_RESET, 1'b1, 1'b0);
        for (int i = 0; q_exp.size() > 0; i++) begin
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_st();
        ifc.ir = 32'h10900067;
        push_fetch(0);
        push(E_MEM3);
        push(RUN | COUT | ZEN | alu(5'b00011));
        push(E_MAR5);
        push(RUN | GRA | ROUT | MDRE);
        push(RUN | WR);
        for (int i = 0; q_exp.size() > 0; i++) begin
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL st cyc%0d: got %h want %h", i, obs, exp_v);
            end
            n_cmp++;
            if (ifc.Read === 1'b1 && ifc.Write === 1'b1) begin
                n_bad++;
                $display("FAIL st_rw_excl cyc%0d: got Read=Write=1 want not both", i);
            end
            advance();
        end
    endtask

    task automatic test_ld_stall();
        ifc.ir = 32'h01900010;
        push_fetch(3);
        push(E_MEM3);
        push(RUN | COUT | ZEN | alu(5'b00011));
        push(E_MAR5);
        push(RUN | RD | MDRE, 1'b0);
        push(RUN | RD | MDRE, 1'b0);
        push(RUN | RD | MDRE, 1'b1);
        push(RUN | MDRO | GRA | RIN);
        for (int i = 0; q_exp.size() > 0; i++) begin
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL ld_stall cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_alu_ops();
        ifc.ir = 32'h49A28000;
        push_fetch(0);
        push(E_REG3);
        push(RUN | GRC | ROUT | ZEN | alu(5'b01001));
        push(E_WB5);
        for (int i = 0; q_exp.size() > 0; i++) begin
            if (i == 3) ifc.ir = 32'h20000000;
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL and_rrr cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_immediates();
        // ldi then ori back-to-back; ir swapped during the first T3 (op already latched).
        ifc.ir = 32'h08800005;
        push_fetch(0);
        push(E_MEM3);
        push(RUN | COUT | ZEN | alu(5'b00011));
        push(E_WB5);
        push_fetch(0);
        push(E_REG3);
        push(RUN | COUT | ZEN | alu(5'b01010));
        push(E_WB5);
        for (int i = 0; q_exp.size() > 0; i++) begin
            if (i == 3) ifc.ir = 32'h68880003;
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL ldi_ori cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_br();
        ifc.ir = 32'h90800010;
        for (int c = 0; c < 2; c++) begin
            ifc.con_ff = (c == 1);
            push_fetch(0);
            push(RUN | GRA | ROUT | CONI);
            push(RUN | POUT | YEN);
            push(RUN | COUT | ZEN | alu(5'b00011));
            push((c == 1) ? (RUN | ZLO | PEN) : RUN);
            for (int i = 0; q_exp.size() > 0; i++) begin
                drive_to_sample();
                obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL br_con%0d cyc%0d: got %h want %h", c, i, obs, exp_v);
                end
                advance();
            end
        end
        ifc.con_ff = 1'b0;
    endtask

    task automatic test_nop();
        // nop, then unlisted opcode 10000 which must also behave as nop.
        ifc.ir = 32'hC8000000;
        push_fetch(0);
        push(RUN);
        push_fetch(0);
        push(RUN);
        for (int i = 0; q_exp.size() > 0; i++) begin
            if (i == 4) ifc.ir = 32'h80000000;
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL nop cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_st();
        ifc.ir = 32'h10900067;
        push_fetch(0);
        push(E_MEM3);
        push(RUN | COUT | ZEN | alu(5'b00011));
        push(E_MAR5);
        push(RUN | GRA | ROUT | MDRE, 1'b1, 1'b1);
        push(E_RESET, 1'b1, 1'b1);
        push(E_RESET, 1'b1, 1'b0);
        push(E_T0);
        for (int i = 0; q_exp.size() > 0; i++) begin
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid_st cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        // Starts in T1: the previous task already consumed this instruction's T0.
        ifc.ir = 32'hD0000000;
        push(E_T1);
        push(E_T2);
        push(RUN);
        repeat (20) push(26'd0);
        push(26'd0, 1'b1, 1'b1);
        push(E_RESET);
        push(E_T0);
        for (int i = 0; q_exp.size() > 0; i++) begin
            drive_to_sample();
            obs = pack(); exp_v = q_exp.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL halt cyc%0d: got %h want %h", i, obs, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_st();
        test_ld_stall();
        test_alu_ops();
        test_immediates();
        test_br();
        test_nop();
        test_reset_mid_st();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
